// File: rtl/phys_reg_file_mp.sv
// Multi-ported physical register file with per-register ready bits for an out-of-order rename/issue stage.
// Optional macro PRF_WB_BYPASS_EN forwards same-cycle writeback data to the read ports.
module phys_reg_file_mp #(
    parameter int  DATA_W    = 32,
    parameter int  NUM_PREGS = 128,
    parameter int  NUM_WR    = 3,
    parameter int  NUM_RD    = 6,
    parameter int  NUM_ALLOC = 1,
    localparam int PREG_W    = $clog2(NUM_PREGS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_WR-1:0]           wr_en,
    input  logic [NUM_WR*PREG_W-1:0]    wr_pd,
    input  logic [NUM_WR*DATA_W-1:0]    wr_data,
    input  logic [NUM_ALLOC-1:0]        alloc_en,
    input  logic [NUM_ALLOC*PREG_W-1:0] alloc_pd,
    input  logic                        flush,
    input  logic [NUM_RD-1:0]           rd_en,
    input  logic [NUM_RD*PREG_W-1:0]    rd_ps,
    output logic [NUM_RD*DATA_W-1:0]    rd_data,
    output logic [NUM_RD-1:0]           rd_ready
);

    logic [DATA_W-1:0]    r_data [NUM_PREGS];
    logic [NUM_PREGS-1:0] r_ready;

    // NOTE: the data array is reset as a whole because rename relies on every
    // register reading a known zero after reset; this rules out a RAM macro.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PREGS; i++) begin
                r_data[i] <= '0;
            end
            r_ready <= '1;
        end else begin
            // NOTE: priority comes from statement order: with non-blocking
            // assignments the last one scheduled for an element wins, so the
            // highest write port beats lower ones, allocate beats write on the
            // ready bit, and flush beats both.
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_en[k] && (wr_pd[k*PREG_W +: PREG_W] != '0)) begin
                    r_data[wr_pd[k*PREG_W +: PREG_W]]  <= wr_data[k*DATA_W +: DATA_W];
                    r_ready[wr_pd[k*PREG_W +: PREG_W]] <= 1'b1;
                end
            end
            for (int j = 0; j < NUM_ALLOC; j++) begin
                if (alloc_en[j] && (alloc_pd[j*PREG_W +: PREG_W] != '0)) begin
                    r_ready[alloc_pd[j*PREG_W +: PREG_W]] <= 1'b0;
                end
            end
            if (flush) begin
                r_ready <= '1;
            end
        end
    end

    // NOTE: outputs get a default before the loop so no path leaves them
    // unassigned, which would otherwise infer latches.
    always_comb begin
        rd_data  = '0;
        rd_ready = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            if (reset && rd_en[r]) begin
                if (rd_ps[r*PREG_W +: PREG_W] == '0) begin
                    rd_ready[r] = 1'b1;
                end else begin
                    rd_data[r*DATA_W +: DATA_W] = r_data[rd_ps[r*PREG_W +: PREG_W]];
                    rd_ready[r]                 = r_ready[rd_ps[r*PREG_W +: PREG_W]];
`ifdef PRF_WB_BYPASS_EN
                    for (int k = 0; k < NUM_WR; k++) begin
                        if (wr_en[k] && (wr_pd[k*PREG_W +: PREG_W] == rd_ps[r*PREG_W +: PREG_W])) begin
                            rd_data[r*DATA_W +: DATA_W] = wr_data[k*DATA_W +: DATA_W];
                            rd_ready[r]                 = 1'b1;
                        end
                    end
`else
                    // Same-cycle writebacks become visible after the next edge.
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_phys_reg_file_mp.sv
// Self-checking bench for phys_reg_file_mp: directed corner cases followed by
// randomized traffic, all compared against a per-register reference model.
module tb_phys_reg_file_mp;

    localparam int DATA_W    = 32;
    localparam int NUM_PREGS = 128;
    localparam int NUM_WR    = 3;
    localparam int NUM_RD    = 6;
    localparam int NUM_ALLOC = 1;
    localparam int PREG_W    = $clog2(NUM_PREGS);

    logic                        clk = 1'b0;
    logic                        reset;
    logic [NUM_WR-1:0]           wr_en;
    logic [NUM_WR*PREG_W-1:0]    wr_pd;
    logic [NUM_WR*DATA_W-1:0]    wr_data;
    logic [NUM_ALLOC-1:0]        alloc_en;
    logic [NUM_ALLOC*PREG_W-1:0] alloc_pd;
    logic                        flush;
    logic [NUM_RD-1:0]           rd_en;
    logic [NUM_RD*PREG_W-1:0]    rd_ps;
    logic [NUM_RD*DATA_W-1:0]    rd_data;
    logic [NUM_RD-1:0]           rd_ready;

    phys_reg_file_mp #(
        .DATA_W(DATA_W), .NUM_PREGS(NUM_PREGS), .NUM_WR(NUM_WR),
        .NUM_RD(NUM_RD), .NUM_ALLOC(NUM_ALLOC)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_pd(wr_pd), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_pd(alloc_pd), .flush(flush),
        .rd_en(rd_en), .rd_ps(rd_ps), .rd_data(rd_data), .rd_ready(rd_ready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [DATA_W-1:0] m_data  [NUM_PREGS];
    bit                m_ready [NUM_PREGS];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NUM_PREGS; p++) begin
            m_data[p]  = '0;
            m_ready[p] = 1'b1;
        end
    endtask

    // Each register decides its own next state from "who wrote / allocated / flushed it".
    task automatic model_edge();
        if (!reset) return;
        for (int p = 1; p < NUM_PREGS; p++) begin
            bit                wrote   = 1'b0;
            bit                alloced = 1'b0;
            logic [DATA_W-1:0] nd      = m_data[p];
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_en[k] && int'(wr_pd[k*PREG_W +: PREG_W]) == p) begin
                    wrote = 1'b1;
                    nd    = wr_data[k*DATA_W +: DATA_W];
                end
            end
            for (int j = 0; j < NUM_ALLOC; j++) begin
                if (alloc_en[j] && int'(alloc_pd[j*PREG_W +: PREG_W]) == p) alloced = 1'b1;
            end
            m_data[p] = nd;
            if (flush)        m_ready[p] = 1'b1;
            else if (alloced) m_ready[p] = 1'b0;
            else if (wrote)   m_ready[p] = 1'b1;
        end
    endtask

    task automatic exp_read(input int r, output logic [DATA_W-1:0] d, output logic rdy);
        int ps;
        ps  = int'(rd_ps[r*PREG_W +: PREG_W]);
        d   = '0;
        rdy = 1'b0;
        if (reset && rd_en[r]) begin
            if (ps == 0) begin
                rdy = 1'b1;
            end else begin
                d   = m_data[ps];
                rdy = m_ready[ps];
`ifdef PRF_WB_BYPASS_EN
                for (int k = 0; k < NUM_WR; k++) begin
                    if (wr_en[k] && int'(wr_pd[k*PREG_W +: PREG_W]) == ps) begin
                        d   = wr_data[k*DATA_W +: DATA_W];
                        rdy = 1'b1;
                    end
                end
`endif
            end
        end
    endtask

    task automatic look(input string tag);
        logic [DATA_W-1:0] d;
        logic              rdy;
        #1;
        for (int r = 0; r < NUM_RD; r++) begin
            exp_read(r, d, rdy);
            check($sformatf("%s.rd%0d.data", tag, r), 64'(rd_data[r*DATA_W +: DATA_W]), 64'(d));
            check($sformatf("%s.rd%0d.ready", tag, r), 64'(rd_ready[r]), 64'(rdy));
        end
    endtask

    task automatic advance();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        wr_en = '0; wr_pd = '0; wr_data = '0;
        alloc_en = '0; alloc_pd = '0; flush = 1'b0;
        rd_en = '0; rd_ps = '0;
    endtask

    task automatic set_wr(input int k, input int pd, input logic [DATA_W-1:0] d);
        wr_en[k] = 1'b1;
        wr_pd[k*PREG_W +: PREG_W]   = PREG_W'(pd);
        wr_data[k*DATA_W +: DATA_W] = d;
    endtask

    task automatic set_alloc(input int pd);
        alloc_en[0] = 1'b1;
        alloc_pd[0 +: PREG_W] = PREG_W'(pd);
    endtask

    task automatic set_rd(input int r, input int ps);
        rd_en[r] = 1'b1;
        rd_ps[r*PREG_W +: PREG_W] = PREG_W'(ps);
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);

        // Reset held: every port reads zero / not-ready regardless of rd_en.
        rd_en = '1;
        for (int r = 0; r < NUM_RD; r++) rd_ps[r*PREG_W +: PREG_W] = PREG_W'(5);
        look("in_reset");
        check("in_reset.lit_ready", 64'(rd_ready), 64'(0));
        check("in_reset.lit_data", 64'(rd_data[DATA_W-1:0]), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        look("post_reset");
        check("post_reset.lit_ready", 64'(rd_ready), 64'({NUM_RD{1'b1}}));
        advance();

        // Allocate clears ready, writeback sets it again.
        clear_inputs(); set_alloc(10); look("alloc10"); advance();
        clear_inputs(); set_rd(0, 10); set_wr(0, 10, 32'hDEADBEEF); look("wr10");
`ifndef PRF_WB_BYPASS_EN
        check("wr10.lit_ready", 64'(rd_ready[0]), 64'(0));
`endif
        advance();
        clear_inputs(); set_rd(0, 10); look("rd10");
        check("rd10.lit_data", 64'(rd_data[DATA_W-1:0]), 64'h0000_0000_DEAD_BEEF);
        check("rd10.lit_ready", 64'(rd_ready[0]), 64'(1));
        advance();

        // Same-register write collision, and writes to register 0.
        clear_inputs(); set_wr(0, 7, 32'h11); set_wr(2, 7, 32'h33); set_wr(1, 0, 32'hFFFF);
        look("coll7"); advance();
        clear_inputs(); set_rd(0, 7); set_rd(1, 0); look("rd7");
        check("rd7.lit_data", 64'(rd_data[DATA_W-1:0]), 64'h33);
        check("rd0.lit_data", 64'(rd_data[DATA_W +: DATA_W]), 64'(0));
        check("rd0.lit_ready", 64'(rd_ready[1]), 64'(1));
        advance();

        // Allocate wins the ready bit over a same-cycle write; flush restores it.
        clear_inputs(); set_alloc(20); set_wr(1, 20, 32'h55); look("alloc_wr20"); advance();
        clear_inputs(); set_rd(0, 20); flush = 1'b1; look("rd20");
        check("rd20.lit_data", 64'(rd_data[DATA_W-1:0]), 64'h55);
        check("rd20.lit_ready", 64'(rd_ready[0]), 64'(0));
        advance();
        clear_inputs(); set_rd(0, 20); look("flush20");
        check("flush20.lit_ready", 64'(rd_ready[0]), 64'(1));
        advance();

        // Same-cycle write and read of p3.
        clear_inputs(); set_wr(0, 3, 32'hA5); set_rd(0, 3); look("byp3");
`ifdef PRF_WB_BYPASS_EN
        check("byp3.lit_data", 64'(rd_data[DATA_W-1:0]), 64'hA5);
`else
        check("byp3.lit_data", 64'(rd_data[DATA_W-1:0]), 64'(0));
`endif
        advance();
        clear_inputs(); set_rd(0, 3); look("rd3");
        check("rd3.lit_data", 64'(rd_data[DATA_W-1:0]), 64'hA5);
        advance();

        // Reset asserted mid-operation clears stored data.
        clear_inputs(); set_wr(0, 9, 32'h1234); look("wr9"); advance();
        clear_inputs(); set_rd(0, 9); look("rd9");
        check("rd9.lit_data", 64'(rd_data[DATA_W-1:0]), 64'h1234);
        reset = 1'b0;
        model_reset();
        look("mid_reset");
        @(negedge clk);
        reset = 1'b1;
        look("rd9_after");
        check("rd9_after.lit_data", 64'(rd_data[DATA_W-1:0]), 64'(0));
        check("rd9_after.lit_ready", 64'(rd_ready[0]), 64'(1));
        advance();

        // Randomized traffic concentrated on a few registers to force collisions.
        for (int c = 0; c < 1500; c++) begin
            clear_inputs();
            for (int k = 0; k < NUM_WR; k++) begin
                if ($urandom_range(0, 1) == 1) set_wr(k, int'($urandom_range(0, 15)), $urandom);
            end
            if ($urandom_range(0, 2) == 0) set_alloc(int'($urandom_range(0, 15)));
            flush = ($urandom_range(0, 15) == 0);
            for (int r = 0; r < NUM_RD; r++) begin
                if ($urandom_range(0, 3) != 0) set_rd(r, int'($urandom_range(0, 15)));
                else rd_ps[r*PREG_W +: PREG_W] = PREG_W'($urandom_range(0, 15));
            end
            look($sformatf("rnd%0d", c));
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/phys_reg_file_mp.md
PHYS_REG_FILE_MP -- requirements
Module: phys_reg_file_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the width of each physical register in bits.
REQ-002 SHALL have parameter NUM_PREGS, default 128, meaning the number of physical registers (power of two, at least 4).
REQ-003 SHALL have parameter NUM_WR, default 3, meaning the number of writeback ports.
REQ-004 SHALL have parameter NUM_RD, default 6, meaning the number of read ports.
REQ-005 SHALL have parameter NUM_ALLOC, default 1, meaning the number of rename-allocate ports; localparam PREG_W = $clog2(NUM_PREGS).
REQ-006 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset  input  1  reset, asynchronous and active-low (0 = in reset).
REQ-008 SHALL have port wr_en  input  NUM_WR  per-port writeback valid.
REQ-009 SHALL have port wr_pd  input  NUM_WR*PREG_W  per-port destination register; port k occupies slice k.
REQ-010 SHALL have port wr_data  input  NUM_WR*DATA_W  per-port writeback data.
REQ-011 SHALL have port alloc_en  input  NUM_ALLOC  per-port rename allocation valid.
REQ-012 SHALL have port alloc_pd  input  NUM_ALLOC*PREG_W  newly allocated register; its ready bit is cleared.
REQ-013 SHALL have port flush  input  1  pipeline squash; sets all ready bits.
REQ-014 SHALL have port rd_en  input  NUM_RD  per-port read enable.
REQ-015 SHALL have port rd_ps  input  NUM_RD*PREG_W  per-port source register.
REQ-016 SHALL have port rd_data  output  NUM_RD*DATA_W  per-port read data.
REQ-017 SHALL have port rd_ready  output  NUM_RD  per-port ready bit of rd_ps.

Function
REQ-018 SHALL hold NUM_PREGS data entries and NUM_PREGS ready bits.
REQ-019 SHALL write wr_data[k] to entry wr_pd[k] on the clock edge when wr_en[k]=1 and wr_pd[k]!=0, and set that entry's ready bit.
REQ-020 SHALL ignore any write to register 0; entry 0 reads as 0 with rd_ready=1 at all times.
REQ-021 SHALL, when two or more write ports target the same register in one cycle, store the data of the highest-index port.
REQ-022 SHALL clear the ready bit of alloc_pd[j] on the clock edge when alloc_en[j]=1 and alloc_pd[j]!=0, without changing its data.
REQ-023 SHALL, when an allocate and a writeback target the same register in one cycle, store the write data and leave the ready bit cleared (allocate wins the ready bit).
REQ-024 SHALL, on flush=1 at the clock edge, set all ready bits to 1; flush has priority over allocate, and same-cycle writes still update data.
REQ-025 SHALL produce read results combinationally (zero-cycle latency): rd_data/rd_ready reflect stored state for rd_ps when rd_en=1.
REQ-026 SHALL drive rd_data=0 and rd_ready=0 on any port with rd_en=0.
REQ-027 SHALL allow any number of read ports to address the same register in one cycle.

Reset
REQ-028 SHALL, while reset=0, asynchronously clear all data entries to 0 and set all ready bits to 1.
REQ-029 SHALL drive every rd_data to 0 and every rd_ready to 0 while reset=0, regardless of rd_en.
REQ-030 SHALL discard writes, allocates and flush presented in the cycle reset deasserts only if reset is still low at that clock edge; the first edge with reset=1 performs normal updates.

Configuration
REQ-031 SHALL, when macro PRF_WB_BYPASS_EN is defined, forward same-cycle writeback data: a read port with rd_en=1 whose rd_ps!=0 matches an active wr_pd returns that port's wr_data (highest-index matching port) and rd_ready=1.
REQ-032 SHALL, when PRF_WB_BYPASS_EN is not defined, return only previously stored state; same-cycle writes become visible on the following cycle.

Verification
REQ-033 SHALL cover: reset low with rd_en all 1, rd_ps=5 -> rd_data=0, rd_ready=0; after release, read p5 -> data 0, ready 1.
REQ-034 SHALL cover: alloc p10, next cycle read p10 -> ready 0; wr p10=0xDEADBEEF, next cycle read -> 0xDEADBEEF, ready 1.
REQ-035 SHALL cover: wr ports 0 and 2 both write p7 with 0x11 and 0x33 -> p7 reads 0x33; wr p0=0xFFFF -> p0 reads 0, ready 1.
REQ-036 SHALL cover: alloc p20 and wr p20=0x55 same cycle -> p20 data 0x55, ready 0; then flush -> ready 1.
REQ-037 SHALL cover: wr p3=0xA5 and read p3 same cycle -> with PRF_WB_BYPASS_EN 0xA5/ready 1 that cycle; without, old value that cycle and 0xA5 next cycle.
REQ-038 SHALL cover: reset asserted mid-operation after p9=0x1234 written -> p9 reads 0 and ready 1 after reset release.
